// File: rtl/rad4_dot_acc.sv
// Dot-product accumulator for a radix-4 Booth multiplier stream.
// Sums VEC_LEN signed products with saturation. Each finished vector is
// placed in a one-deep output register that has a valid/ready handshake.
module rad4_dot_acc #(
  parameter int unsigned DATA_WIDTH_1 = 8,
  parameter int unsigned DATA_WIDTH_2 = 8,
  parameter int unsigned VEC_LEN      = 4,
  parameter int unsigned ACC_WIDTH    = 20,
  localparam int unsigned PROD_WIDTH  = DATA_WIDTH_1 + DATA_WIDTH_2 + 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         p_valid,
  output logic                         p_ready,
  input  logic signed [PROD_WIDTH-1:0] p_data,
  input  logic                         acc_clr,
  output logic signed [ACC_WIDTH-1:0]  acc_o,
  output logic                         sat_o,
  output logic                         acc_valid,
  input  logic                         acc_ready
);

  localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(VEC_LEN - 1);
  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {StEmpty, StFull} occ_e;

  occ_e                        occ_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        vsat_q;

  logic signed [ACC_WIDTH:0]   sum;
  logic signed [ACC_WIDTH-1:0] sat_val;
  logic                        clamp;
  logic                        last;
  logic                        p_xfer;
  logic                        r_xfer;

  assign acc_valid = (occ_q == StFull);
  assign last      = (cnt_q == CntLast);
  // Stall only the last term while the previous result is still unconsumed.
  assign p_ready   = !acc_clr && !(last && acc_valid && !acc_ready);
  assign p_xfer    = p_valid && p_ready;
  assign r_xfer    = acc_valid && acc_ready;

  // One extra bit of headroom lets the sign pair detect overflow.
  always_comb begin
    sum     = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(p_data);
    clamp   = 1'b0;
    sat_val = sum[ACC_WIDTH-1:0];
    if (!sum[ACC_WIDTH] && sum[ACC_WIDTH-1]) begin
      sat_val = AccMax;
      clamp   = 1'b1;
    end else if (sum[ACC_WIDTH] && !sum[ACC_WIDTH-1]) begin
      sat_val = AccMin;
      clamp   = 1'b1;
    end
  end

  // Accumulator, term counter, output register and occupancy state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      vsat_q <= 1'b0;
      acc_o  <= '0;
      sat_o  <= 1'b0;
      occ_q  <= StEmpty;
    end else begin
      if (acc_clr) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        vsat_q <= 1'b0;
      end else if (p_xfer) begin
        if (last) begin
          acc_o  <= sat_val;
          sat_o  <= vsat_q | clamp;
          acc_q  <= '0;
          cnt_q  <= '0;
          vsat_q <= 1'b0;
        end else begin
          acc_q  <= sat_val;
          cnt_q  <= cnt_q + CNT_W'(1);
          vsat_q <= vsat_q | clamp;
        end
      end
      // A new result overrides a same-edge consume, so nothing is lost.
      if (p_xfer && last) begin
        occ_q <= StFull;
      end else if (r_xfer) begin
        occ_q <= StEmpty;
      end
    end
  end

endmodule
